// File: rtl/kb_arb_pkg.sv
// Shared types and constants for the keyboard / CPU data-memory write arbiter.
//   KB_BREAK, KB_EXT  : PS/2 set-2 prefix bytes (release, extended)
//   kb_dec_state_t    : scan-byte decoder states
//   kb_word_t         : 32-bit key word written to memory
package kb_arb_pkg;

  localparam int unsigned KB_WORD_W = 32;
  localparam int unsigned KB_CODE_W = 8;

  localparam logic [KB_CODE_W-1:0] KB_BREAK = 8'hF0;
  localparam logic [KB_CODE_W-1:0] KB_EXT   = 8'hE0;

  typedef logic [KB_WORD_W-1:0] kb_word_t;

  typedef enum logic [1:0] {
    S_NORMAL,
    S_EXT,
    S_BREAK
  } kb_dec_state_t;

  // Key word layout: bit 8 flags an E0-prefixed code, bits 7:0 carry the code.
  function automatic kb_word_t kb_make_word(input logic ext, input logic [KB_CODE_W-1:0] code);
    return {23'b0, ext, code};
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Synchronous key-event FIFO.
//   clk, rst (async, active-low)
//   push, push_data : enqueue request and word
//   pop             : dequeue request (ignored when empty)
//   full, empty     : status (combinational from pointers)
//   head            : word at the read pointer
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kb_fifo
  import kb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [KB_WORD_W-1:0] push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [KB_WORD_W-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [KB_WORD_W-1:0] mem [DEPTH];
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/kb_mem_arbiter.sv
// Keyboard event buffer and data-memory write-port arbiter.
// Scan bytes from the PS/2 receiver are turned into key words, queued, and
// written to KB_ADDR whenever the CPU is not storing; a starvation counter
// forces a keyboard slot after STARVE_LIMIT lost cycles.
// Optional build macro KB_ARB_BREAK_FILTER_EN: when defined, a decoder drops
// break sequences and tags E0-prefixed codes; when undefined every byte is
// queued raw.
// Ports:
//   clk, rst (async, active-low)
//   key_code, key_valid             : scan byte strobe from PS/2 receiver
//   cpu_we, cpu_addr, cpu_wdata     : CPU store request
//   cpu_stall                       : CPU store refused this cycle (comb)
//   mem_we, mem_addr, mem_wdata     : data-memory write port (comb)
//   key_ready                       : pulse, key word committed last cycle
//   ovf_clr, overflow               : sticky dropped-event flag and its clear
module kb_mem_arbiter
  import kb_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] KB_ADDR      = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        key_ready,
  input  logic        ovf_clr,
  output logic        overflow
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic                 push_c;
  logic [KB_WORD_W-1:0] push_word;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [KB_WORD_W-1:0] fifo_head;
  logic                 kb_grant;
  logic                 drop_c;
  logic [SW-1:0]        starve_cnt;

`ifdef KB_ARB_BREAK_FILTER_EN
  kb_dec_state_t dec_state;
  kb_dec_state_t dec_state_nxt;

  // Decoder state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dec_state <= S_NORMAL;
    else      dec_state <= dec_state_nxt;
  end

  // Prefix bytes only steer the decoder; the byte after F0 is a release and is dropped.
  always_comb begin
    dec_state_nxt = dec_state;
    push_c        = 1'b0;
    push_word     = kb_make_word(1'b0, key_code);
    if (key_valid) begin
      case (dec_state)
        S_NORMAL: begin
          if (key_code == KB_BREAK)    dec_state_nxt = S_BREAK;
          else if (key_code == KB_EXT) dec_state_nxt = S_EXT;
          else                         push_c        = 1'b1;
        end
        S_EXT: begin
          if (key_code == KB_BREAK) begin
            dec_state_nxt = S_BREAK;
          end else begin
            push_c        = 1'b1;
            push_word     = kb_make_word(1'b1, key_code);
            dec_state_nxt = S_NORMAL;
          end
        end
        S_BREAK:  dec_state_nxt = S_NORMAL;
        default:  dec_state_nxt = S_NORMAL;
      endcase
    end
  end
`else
  // No decoding: every received byte becomes a key word.
  assign push_c    = key_valid;
  assign push_word = {24'b0, key_code};
`endif

  kb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_word),
    .pop       (kb_grant),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // CPU wins unless idle or the keyboard has waited STARVE_LIMIT cycles.
  assign kb_grant = ~fifo_empty & (~cpu_we | (starve_cnt == SW'(STARVE_LIMIT)));
  assign drop_c   = push_c & fifo_full & ~kb_grant;

  // Write-port mux.
  always_comb begin
    mem_we    = cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (kb_grant) begin
      mem_we    = 1'b1;
      mem_addr  = KB_ADDR;
      mem_wdata = fifo_head;
      cpu_stall = cpu_we;
    end
  end

  // Starvation counter, commit pulse and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      key_ready  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      key_ready <= kb_grant;
      if (fifo_empty || kb_grant)
        starve_cnt <= '0;
      else if (cpu_we && (starve_cnt != SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + SW'(1);
      if (drop_c)       overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kb_mem_arbiter.sv
// Scoreboard bench for kb_mem_arbiter: stimulus queues the expected key words,
// a negedge monitor checks every keyboard write and the key_ready pulse after it.
module tb_kb_mem_arbiter;

  localparam logic [31:0] KB_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_code;
  logic        key_valid;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        key_ready;
  logic        ovf_clr;
  logic        overflow;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          m_state = 0;
  logic        prev_kb = 1'b0;

  kb_mem_arbiter #(
    .FIFO_DEPTH   (4),
    .KB_ADDR      (KB_ADDR),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_valid (key_valid),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .key_ready (key_ready),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decoder: queues the word a byte should produce.
  task automatic model_key(input logic [7:0] c);
`ifdef KB_ARB_BREAK_FILTER_EN
    case (m_state)
      0: begin
        if (c == 8'hF0)      m_state = 2;
        else if (c == 8'hE0) m_state = 1;
        else                 exp_q.push_back({24'h0, c});
      end
      1: begin
        if (c == 8'hF0) m_state = 2;
        else begin
          exp_q.push_back({23'h0, 1'b1, c});
          m_state = 0;
        end
      end
      default: m_state = 0;
    endcase
`else
    exp_q.push_back({24'h0, c});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] c, input bit expect_it);
    key_valid = 1'b1;
    key_code  = c;
    if (expect_it) model_key(c);
    tick();
    key_valid = 1'b0;
  endtask

  // Monitor: every keyboard write must match the queue head; key_ready follows one cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      prev_kb = 1'b0;
    end else begin
      if (prev_kb || key_ready) chk("key_ready", {31'b0, key_ready}, {31'b0, prev_kb});
      prev_kb = mem_we && (mem_addr == KB_ADDR);
      if (prev_kb) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_key_write: got %h expected none at %0t", mem_wdata, $time);
        end else begin
          chk("key_word", mem_wdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    key_code  = 8'h00;
    key_valid = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    ovf_clr   = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_we",    {31'b0, mem_we},    32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_mem_wdata", mem_wdata,          32'h0);
    chk("rst_key_ready", {31'b0, key_ready}, 32'h0);
    chk("rst_overflow",  {31'b0, overflow},  32'h0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Make then break of the same key; latency check on the first key
    send(8'h5A, 1'b1);
    @(negedge clk);
    chk("lat_mem_we",   {31'b0, mem_we}, 32'h1);
    chk("lat_mem_addr", mem_addr,        KB_ADDR);
    tick();
    @(negedge clk);
    chk("lat_key_ready", {31'b0, key_ready}, 32'h1);
    tick();
    send(8'hF0, 1'b1);
    send(8'h5A, 1'b1);
    idle(4);

    // Extended key press and release
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    idle(6);

    // Raw prefix then code
    send(8'hF0, 1'b1);
    send(8'h5A, 1'b1);
    idle(4);

    // Contention: 8 CPU wins, then a forced keyboard slot
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0200;
    cpu_wdata = 32'hC0DE_0000;
    send(8'h29, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_cpu_addr",  mem_addr,           32'h0000_0200);
      chk("cont_cpu_stall", {31'b0, cpu_stall}, 32'h0);
      tick();
    end
    @(negedge clk);
    chk("cont_kb_addr",  mem_addr,           KB_ADDR);
    chk("cont_kb_data",  mem_wdata,          32'h0000_0029);
    chk("cont_kb_stall", {31'b0, cpu_stall}, 32'h1);
    tick();
    @(negedge clk);
    chk("cont_after_stall", {31'b0, cpu_stall}, 32'h0);
    chk("cont_after_addr",  mem_addr,           32'h0000_0200);
    tick();
    cpu_we = 1'b0;
    idle(3);

    // Overflow: fill under CPU pressure, drop the 5th, set beats clear
    cpu_we   = 1'b1;
    cpu_addr = 32'h0000_0300;
    send(8'h16, 1'b1);
    send(8'h1E, 1'b1);
    send(8'h26, 1'b1);
    send(8'h25, 1'b1);
    send(8'h2E, 1'b0);
    key_valid = 1'b1;
    key_code  = 8'h36;
    ovf_clr   = 1'b1;
    @(negedge clk);
    chk("ovf_set",        {31'b0, overflow},  32'h1);
    chk("ovf_full_stall", {31'b0, cpu_stall}, 32'h0);
    chk("ovf_full_addr",  mem_addr,           32'h0000_0300);
    tick();
    // Push and pop together at full: nothing dropped
    cpu_we   = 1'b0;
    ovf_clr  = 1'b0;
    key_code = 8'h3D;
    model_key(8'h3D);
    @(negedge clk);
    chk("ovf_set_wins",   {31'b0, overflow}, 32'h1);
    chk("ovf_full_grant", mem_addr,          KB_ADDR);
    tick();
    key_valid = 1'b0;
    ovf_clr   = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {31'b0, overflow}, 32'h0);
    tick();
    idle(8);

    // Reset mid-operation with entries queued
    cpu_we   = 1'b1;
    cpu_addr = 32'h0000_0400;
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    @(negedge clk);
    #2;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    rst       = 1'b0;
    #1;
    chk("mid_rst_mem_we",    {31'b0, mem_we},    32'h0);
    chk("mid_rst_mem_addr",  mem_addr,           32'h0);
    chk("mid_rst_mem_wdata", mem_wdata,          32'h0);
    chk("mid_rst_key_ready", {31'b0, key_ready}, 32'h0);
    chk("mid_rst_overflow",  {31'b0, overflow},  32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    m_state = 0;
    idle(4);
    @(negedge clk);
    chk("post_rst_empty", {31'b0, mem_we}, 32'h0);
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kb_mem_arbiter.md
Name: kb_mem_arbiter

Overview:
- Sits between the PS/2 receiver and the data memory write port of the Gambling_Tec top.
- Decodes raw scan bytes into make-code events and buffers them in a small FIFO.
- Arbitrates the single data-memory write port between the CPU store path and keyboard commits to KB_ADDR.
- CPU has priority, bounded by an anti-starvation slot.

Parameters:
- FIFO_DEPTH, 4, key event buffer entries (power of two, ≥2)
- KB_ADDR, 32'h0000_0000, byte address written with each key word
- STARVE_LIMIT, 8, consecutive CPU-won cycles with a pending key before the keyboard is forced a slot

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_code  in  8  scan byte from PS/2 receiver
- key_valid  in  1  one-cycle strobe, key_code valid
- cpu_we  in  1  CPU store request
- cpu_addr  in  32  CPU store address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU store not accepted this cycle
- mem_we  out  1  data memory write enable
- mem_addr  out  32  data memory address
- mem_wdata  out  32  data memory write data
- key_ready  out  1  one-cycle pulse: key word committed to memory
- ovf_clr  in  1  clears overflow flag
- overflow  out  1  sticky, a key event was dropped on full FIFO

Behaviour:
- Reset (rst=0, async): decode FSM=S_NORMAL, FIFO empty, starve counter=0, key_ready=0, overflow=0. With cpu_we=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Decode FSM (advances only on key_valid):
  - S_NORMAL: F0→S_BREAK; E0→S_EXT; other code→push {23'b0,1'b0,code}, stay.
  - S_EXT: F0→S_BREAK; other code→push {23'b0,1'b1,code}, →S_NORMAL.
  - S_BREAK: any byte discarded, →S_NORMAL (key release ignored).
- Push is registered: key_valid in cycle N makes the entry visible (FIFO non-empty) in cycle N+1.
- Arbitration is combinational each cycle:
  - kb_grant = fifo_nonempty & (~cpu_we | starve_cnt==STARVE_LIMIT).
  - kb_grant=1: mem_we=1, mem_addr=KB_ADDR, mem_wdata=FIFO head; pop at edge; key_ready=1 the following cycle; cpu_stall=cpu_we.
  - Otherwise: mem_* follow cpu_*, cpu_stall=0.
  - Minimum key latency: key_valid cycle N → mem_we for the key in N+1 → key_ready in N+2.
- Starve counter:
  - Increments when cpu_we & fifo_nonempty & ~kb_grant.
  - Resets to 0 on kb_grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO boundaries:
  - Full, push, no pop: event dropped, overflow←1.
  - Full, push, and pop in the same cycle: both occur, no drop.
  - Empty: no pop, kb_grant=0.
  - Pointers wrap modulo FIFO_DEPTH, with an extra MSB distinguishing full from empty.
- ovf_clr with a simultaneous drop: set wins, overflow stays 1.
- Prefix bytes (F0/E0) never enter the FIFO and never set overflow.

Optional Feature:
- Macro KB_ARB_BREAK_FILTER_EN.
- Defined: decode FSM as above.
- Undefined: FSM removed; every key_valid byte is pushed raw as {24'b0,key_code}, including F0/E0. Arbitration is unchanged.

Decomposition:
- Package kb_arb_pkg holds:
  - Constants KB_BREAK=8'hF0 and KB_EXT=8'hE0.
  - Enum kb_dec_state_t {S_NORMAL,S_EXT,S_BREAK}.
  - Typedef kb_word_t (32-bit key word).
- Sub-module kb_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised on FIFO_DEPTH, async active-low reset.

Test Plan:
- Reset mid-operation: 3 entries queued, pull rst low → immediately empty, mem_we=0, overflow=0, key_ready=0.
- Make/break filtering: bytes 5A, F0, 5A with cpu_we=0 → exactly one write, mem_wdata=32'h0000_005A at KB_ADDR, one key_ready pulse.
- Extended key: bytes E0, 75, E0, F0, 75 → one write, 32'h0000_0175.
- Contention: cpu_we held high with key 29 pending, STARVE_LIMIT=8 → 8 CPU writes pass, 9th cycle mem_addr=KB_ADDR, wdata=32'h29, cpu_stall=1 for that cycle only.
- Overflow: cpu_we held high, counter forced below limit, 5 make codes into a 4-deep FIFO → overflow=1, 4 entries drained in order. A simultaneous push+pop at full drops nothing. ovf_clr→0.
- Macro off: bytes F0, 5A → two writes, 32'h0000_00F0 then 32'h0000_005A.
